regfile_fwd: RTL and testbench
==============================

REGFILE_FWD -- requirements
Module: regfile_fwd

Interface
REQ-001 The block SHALL have parameter DW, default 8, giving the data width in bits.
REQ-002 The block SHALL have parameter AW, default 3, giving the address width; DEPTH = 2**AW entries.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port regwrite, input, 1 bit: write enable.
REQ-006 The block SHALL have port wa, input, AW bits: write address.
REQ-007 The block SHALL have port wd, input, DW bits: write data.
REQ-008 The block SHALL have ports ra1 and ra2, each input, AW bits: read addresses.
REQ-009 The block SHALL have ports rd1 and rd2, each output, DW bits: read data, combinational from ra1/ra2.
REQ-010 The block SHALL have port busy, output, 1 bit, registered: high while the clear sequencer runs.

Function
REQ-011 Entry 0 SHALL be hardwired zero: reads of address 0 return 0 and writes to wa=0 have no effect.
REQ-012 The block SHALL use a two-state machine: CLEAR and READY.
REQ-013 In CLEAR, each clock SHALL write 0 to entry cnt and increment cnt; when cnt = DEPTH-1 is written, the next state SHALL be READY.
REQ-014 busy SHALL equal 1 in CLEAR and 0 in READY, i.e. busy is 1 for exactly DEPTH-1 clocks after rst_n is released.
REQ-015 In CLEAR, regwrite SHALL be ignored (no entry written from wd), and rd1/rd2 SHALL read 0.
REQ-016 In READY, regwrite=1 with wa≠0 SHALL write wd into entry wa at the clock edge, with 1-cycle write latency (value visible from the next cycle without bypass).
REQ-017 In READY, rd1 SHALL equal entry ra1 and rd2 SHALL equal entry ra2, combinationally; both ports may address the same entry simultaneously.
REQ-018 Simultaneous read and write of the same non-zero address SHALL follow REQ-026/REQ-027.
REQ-019 Data SHALL be exactly DW bits; no truncation or extension occurs internally.
REQ-020 cnt SHALL be AW bits wide and SHALL not wrap; DEPTH=2 (AW=1) SHALL give a 1-cycle CLEAR.

Reset
REQ-021 While rst_n=0 at a clock edge, state SHALL become CLEAR, cnt SHALL become 1, and busy SHALL become 1.
REQ-022 Reset asserted mid-CLEAR or mid-READY SHALL restart the full clear sequence from cnt=1; a write presented in the same cycle as reset SHALL be discarded.
REQ-023 rd1/rd2 SHALL read 0 from the first clock edge with rst_n=0 until busy falls.
REQ-024 Entry storage SHALL not be reset directly; it is zeroed only by the clear sequencer.

Configuration
REQ-025 The block SHALL recognise macro REGFILE_BYPASS_EN.
REQ-026 With REGFILE_BYPASS_EN defined, the following SHALL hold in READY: if regwrite=1 and wa=raN≠0, then rdN = wd in the same cycle (write-to-read forwarding).
REQ-027 Without REGFILE_BYPASS_EN, rdN SHALL return the old entry value in that cycle and the new value from the next cycle.

Structure
REQ-028 Package regfile_pkg SHALL hold the state enum (CLEAR, READY) and the default DW/AW localparams.
REQ-029 One sub-module, regfile_clr_seq, SHALL hold the state machine and cnt, and SHALL provide busy, clr_en and clr_addr.
REQ-030 Storage, write mux and read/bypass logic SHALL remain in regfile_fwd.

Verification
REQ-031 Reset release, DW=8, AW=3: hold rst_n=0 for 2 clocks, then release -> busy=1 for exactly 7 clocks then 0; all ra reads = 0x00.
REQ-032 Write in READY: wa=5, wd=0xA5, regwrite=1; next cycle ra1=5, ra2=5 -> rd1=rd2=0xA5; write wa=0, wd=0xFF -> ra1=0 reads 0x00.
REQ-033 Bypass: wa=ra1=3, wd=0x3C, regwrite=1, entry 3 previously 0x11 -> rd1=0x3C in the same cycle with REGFILE_BYPASS_EN, 0x11 without; 0x3C next cycle in both builds.
REQ-034 Write during CLEAR: regwrite=1, wa=2, wd=0x77 at busy cycle 3 -> after busy falls, ra1=2 reads 0x00.
REQ-035 Mid-operation reset: fill entries 1..7 with 0x10..0x70, pulse rst_n=0 for 1 clock -> busy high for 7 clocks, then all entries read 0x00.
REQ-036 Parameter sweep: DW=16, AW=1 -> busy high for 1 clock; write 0xBEEF to wa=1 reads back 0xBEEF.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the forwarding register file.
package regfile_pkg;

    localparam int unsigned DW_DEFAULT = 8;
    localparam int unsigned AW_DEFAULT = 3;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

endpackage

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: after reset walks cnt over entries 1..DEPTH-1 issuing zero writes,
// then parks in READY. busy mirrors the CLEAR state as a registered output.
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int unsigned AW = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          busy,
    output logic          clr_en,
    output logic [AW-1:0] clr_addr
);

    localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;

    // Advance one entry per clock; holding cnt at the last entry avoids any wrap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        if (state_q == CLEAR) begin
            if (cnt_q == LAST_ADDR) begin
                state_d = READY;
                busy_d  = 1'b0;
            end else begin
                cnt_d = cnt_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            cnt_q   <= AW'(1);
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign clr_en   = (state_q == CLEAR);
    assign clr_addr = cnt_q;

endmodule

// File: rtl/regfile_fwd.sv
// Register file with hardwired-zero entry 0, a post-reset clear sequencer and
// optional same-cycle write-to-read forwarding (define REGFILE_BYPASS_EN).
module regfile_fwd
    import regfile_pkg::*;
#(
    parameter int unsigned DW = DW_DEFAULT,
    parameter int unsigned AW = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          regwrite,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    output logic          busy
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic          clr_en;
    logic [AW-1:0] clr_addr;

    logic [DW-1:0] mem_q [DEPTH];
    logic          mem_we_d;
    logic [AW-1:0] mem_wa_d;
    logic [DW-1:0] mem_wd_d;

    regfile_clr_seq #(
        .AW (AW)
    ) u_clr_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .busy     (busy),
        .clr_en   (clr_en),
        .clr_addr (clr_addr)
    );

    // Clear sequencer owns the write port while busy; nothing is written on a reset edge.
    always_comb begin
        mem_we_d = 1'b0;
        mem_wa_d = '0;
        mem_wd_d = '0;
        if (rst_n) begin
            if (clr_en) begin
                mem_we_d = 1'b1;
                mem_wa_d = clr_addr;
            end else if (regwrite && (wa != '0)) begin
                mem_we_d = 1'b1;
                mem_wa_d = wa;
                mem_wd_d = wd;
            end
        end
    end

    // Storage is deliberately not reset; the sequencer zeroes it.
    always_ff @(posedge clk) begin
        if (mem_we_d) begin
            mem_q[mem_wa_d] <= mem_wd_d;
        end
    end

    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (!busy) begin
            if (ra1 != '0) rd1 = mem_q[ra1];
            if (ra2 != '0) rd2 = mem_q[ra2];
`ifdef REGFILE_BYPASS_EN
            if (regwrite && (wa != '0) && (wa == ra1)) rd1 = wd;
            if (regwrite && (wa != '0) && (wa == ra2)) rd2 = wd;
`endif
        end
    end

endmodule

// File: tb/tb_regfile_fwd.sv
// Directed self-checking bench for regfile_fwd: default 8x8 instance plus a DW=16/AW=1 instance.
module tb_regfile_fwd;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        regwrite;
    logic [2:0]  wa, ra1, ra2;
    logic [7:0]  wd, rd1, rd2;
    logic        busy;

    logic        rw_b;
    logic [0:0]  wa_b, ra1_b, ra2_b;
    logic [15:0] wd_b, rd1_b, rd2_b;
    logic        busy_b;

    int checks;
    int errors;

    typedef struct {
        logic       rw;
        logic [2:0] wa;
        logic [7:0] wd;
        logic [2:0] ra1;
        logic [2:0] ra2;
        logic [7:0] e1;
        logic [7:0] e2;
    } vec_t;

    vec_t vt[8];

    regfile_fwd #(.DW(8), .AW(3)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .regwrite (regwrite),
        .wa       (wa),
        .wd       (wd),
        .ra1      (ra1),
        .ra2      (ra2),
        .rd1      (rd1),
        .rd2      (rd2),
        .busy     (busy)
    );

    regfile_fwd #(.DW(16), .AW(1)) u_dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .regwrite (rw_b),
        .wa       (wa_b),
        .wd       (wd_b),
        .ra1      (ra1_b),
        .ra2      (ra2_b),
        .rd1      (rd1_b),
        .rd2      (rd2_b),
        .busy     (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one vector after a falling edge, check the combinational reads, move to next falling edge.
    task automatic apply(input vec_t v, input string tag);
        regwrite = v.rw;
        wa       = v.wa;
        wd       = v.wd;
        ra1      = v.ra1;
        ra2      = v.ra2;
        #1;
        chk({tag, "_rd1"}, 32'(rd1), 32'(v.e1));
        chk({tag, "_rd2"}, 32'(rd2), 32'(v.e2));
        @(negedge clk);
        regwrite = 1'b0;
    endtask

    // Counts busy cycles of both instances after reset release; optionally writes entry 2 at busy cycle 3.
    task automatic run_clear(input bit inject, output int n0, output int n1);
        n0 = 0;
        n1 = 0;
        for (int c = 0; c < 20; c++) begin
            regwrite = inject && (c == 2);
            wa       = 3'd2;
            wd       = 8'h77;
            ra1      = 3'(c);
            ra2      = 3'd7;
            #1;
            if (busy) begin
                n0++;
                chk("clr_rd1", 32'(rd1), 32'h0);
                chk("clr_rd2", 32'(rd2), 32'h0);
            end
            if (busy_b) n1++;
            if (!busy && !busy_b) break;
            @(negedge clk);
        end
        regwrite = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int n0, n1;
        vec_t v;
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        regwrite = 1'b0;
        wa = '0; wd = '0; ra1 = 3'd5; ra2 = 3'd3;
        rw_b = 1'b0; wa_b = '0; wd_b = '0; ra1_b = '0; ra2_b = '0;

        vt[0] = '{1'b0, 3'd0, 8'h00, 3'd2, 3'd0, 8'h00, 8'h00};
        vt[1] = '{1'b1, 3'd5, 8'hA5, 3'd1, 3'd7, 8'h00, 8'h00};
        vt[2] = '{1'b1, 3'd0, 8'hFF, 3'd5, 3'd5, 8'hA5, 8'hA5};
        vt[3] = '{1'b1, 3'd3, 8'h11, 3'd0, 3'd5, 8'h00, 8'hA5};
        vt[4] = '{1'b1, 3'd7, 8'h5A, 3'd3, 3'd0, 8'h11, 8'h00};
        vt[5] = '{1'b0, 3'd0, 8'h00, 3'd7, 3'd3, 8'h5A, 8'h11};
        vt[6] = '{1'b1, 3'd1, 8'h01, 3'd4, 3'd6, 8'h00, 8'h00};
        vt[7] = '{1'b0, 3'd0, 8'h00, 3'd1, 3'd1, 8'h01, 8'h01};

        // Reset held for two clocks
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'h1);
        chk("rst_busy_b", 32'(busy_b), 32'h1);
        chk("rst_rd1", 32'(rd1), 32'h0);
        chk("rst_rd2", 32'(rd2), 32'h0);
        rst_n = 1'b1;

        run_clear(1'b1, n0, n1);
        chk("busy_len", 32'(n0), 32'd7);
        chk("busy_len_b", 32'(n1), 32'd1);
        chk("ready_busy", 32'(busy), 32'h0);

        for (int i = 0; i < 8; i++) apply(vt[i], $sformatf("vec%0d", i));

        // Same-cycle read of an entry being written
        v = '{1'b1, 3'd3, 8'h3C, 3'd3, 3'd7, (BYP ? 8'h3C : 8'h11), 8'h5A};
        apply(v, "byp_same");
        v = '{1'b0, 3'd0, 8'h00, 3'd3, 3'd3, 8'h3C, 8'h3C};
        apply(v, "byp_next");
        v = '{1'b1, 3'd7, 8'h77, 3'd0, 3'd7, 8'h00, (BYP ? 8'h77 : 8'h5A)};
        apply(v, "byp_rd2");
        v = '{1'b1, 3'd0, 8'hEE, 3'd0, 3'd7, 8'h00, 8'h77};
        apply(v, "byp_zero");

        // Narrow/wide instance
        rw_b = 1'b1; wa_b = 1'b1; wd_b = 16'hBEEF; ra1_b = 1'b0; ra2_b = 1'b0;
        #1;
        chk("b_rd0", 32'(rd1_b), 32'h0);
        @(negedge clk);
        rw_b = 1'b0; ra1_b = 1'b1; ra2_b = 1'b1;
        #1;
        chk("b_rd1", 32'(rd1_b), 32'hBEEF);
        chk("b_rd2", 32'(rd2_b), 32'hBEEF);
        @(negedge clk);

        // Fill all entries then reset mid-operation
        for (int i = 1; i < 8; i++) begin
            v = '{1'b1, 3'(i), 8'(i * 16), 3'd0, 3'd0, 8'h00, 8'h00};
            apply(v, "fill");
        end
        v = '{1'b0, 3'd0, 8'h00, 3'd7, 3'd4, 8'h70, 8'h40};
        apply(v, "fill_chk");
        rst_n = 1'b0; regwrite = 1'b1; wa = 3'd4; wd = 8'hEE; ra1 = 3'd7; ra2 = 3'd4;
        @(negedge clk);
        #1;
        chk("mid_rst_busy", 32'(busy), 32'h1);
        chk("mid_rst_rd1", 32'(rd1), 32'h0);
        rst_n = 1'b1;
        regwrite = 1'b0;
        run_clear(1'b0, n0, n1);
        chk("mid_busy_len", 32'(n0), 32'd7);
        chk("mid_busy_len_b", 32'(n1), 32'd1);
        for (int i = 1; i < 8; i++) begin
            v = '{1'b0, 3'd0, 8'h00, 3'(i), 3'(8 - i), 8'h00, 8'h00};
            apply(v, "post_clr");
        end
        ra1_b = 1'b1;
        #1;
        chk("b_post_clr", 32'(rd1_b), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
